// File: rtl/ma_sweep_ctrl.sv
// Sweeps all 16 input vectors across NUM_MA instances sharing one tri-state net,
// enabling one instance at a time and tallying per-instance and cross-instance mismatches.
module ma_sweep_ctrl #(
  parameter int NUM_MA = 4,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  y_bus,
  output logic [3:0]            abcd,
  output logic [NUM_MA-1:0]     tri_e,
  output logic                  busy,
  output logic                  done,
  output logic [5*NUM_MA-1:0]   err_cnt,
  output logic [4:0]            div_cnt
);

  localparam int IW = $clog2(NUM_MA);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    ENABLE = 3'd2,
    GUARD  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [3:0]        settle_cnt;
  logic [NUM_MA-1:0] samples;
  logic [4:0]        err_q [NUM_MA];
  logic              y_ref;
  logic              all_agree;

  assign y_ref     = ((abcd[0] | abcd[1]) & abcd[2]) | (abcd[3] & (abcd[2] | abcd[1]));
  assign all_agree = (samples == '0) || (samples == '1);

  for (genvar gi = 0; gi < NUM_MA; gi++) begin : g_err_pack
    assign err_cnt[5*gi +: 5] = err_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      samples    <= '0;
      abcd       <= '0;
      tri_e      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_cnt    <= '0;
      for (int i = 0; i < NUM_MA; i++) err_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tri_e <= '0;
          if (start) begin
            state   <= DRIVE;
            abcd    <= '0;
            idx     <= '0;
            div_cnt <= '0;
            busy    <= 1'b1;
            for (int i = 0; i < NUM_MA; i++) err_q[i] <= '0;
          end
        end
        DRIVE: begin
          state      <= ENABLE;
          tri_e      <= NUM_MA'(1) << idx;
          settle_cnt <= '0;
        end
        ENABLE: begin
          if (settle_cnt == 4'(SETTLE - 1)) begin
            // Last enabled cycle: the selected instance has had SETTLE cycles to drive.
            samples[idx] <= y_bus;
            if (y_bus != y_ref) err_q[idx] <= err_q[idx] + 5'd1;
            tri_e <= '0;
            state <= GUARD;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        GUARD: begin
          if (idx < IW'(NUM_MA - 1)) begin
            idx        <= idx + 1'b1;
            tri_e      <= NUM_MA'(1) << (idx + 1'b1);
            settle_cnt <= '0;
            state      <= ENABLE;
          end else begin
            if (!all_agree) div_cnt <= div_cnt + 5'd1;
            if (abcd == 4'd15) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              abcd  <= abcd + 4'd1;
              idx   <= '0;
              state <= DRIVE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          tri_e <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ma_sweep_ctrl.sv
// Directed bench for ma_sweep_ctrl: models four instances on a pulled-down shared net
// with selectable faults and checks timing, counters, reset abort and bus discipline.
module tb_ma_sweep_ctrl;

  localparam int NUM_MA = 4;
  localparam int SETTLE = 2;
  localparam int SWEEP  = 208;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                y_bus;
  logic [3:0]          abcd;
  logic [NUM_MA-1:0]   tri_e;
  logic                busy;
  logic                done;
  logic [5*NUM_MA-1:0] err_cnt;
  logic [4:0]          div_cnt;

  int vec_cnt;
  int bad_cnt;
  int fault_mode;   // 0 ideal, 1 instance 1 wrong function, 2 instance 3 stuck-at-0
  int bus_viol;
  int lat;
  int lat2;
  int done_seen;
  logic [NUM_MA-1:0] tri_prev;

  ma_sweep_ctrl #(.NUM_MA(NUM_MA), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_bus(y_bus), .abcd(abcd),
    .tri_e(tri_e), .busy(busy), .done(done), .err_cnt(err_cnt), .div_cnt(div_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic inst_out(input int i, input int mode, input logic [3:0] v);
    logic a, b, c, d;
    {d, c, b, a} = v;
    if (mode == 1 && i == 1) return ((b | c) & a) & d;
    if (mode == 2 && i == 3) return 1'b0;
    return ((a | b) & c) | (d & (c | b));
  endfunction

  // Shared net: wired-OR of enabled drivers, pulled down when undriven.
  always_comb begin
    y_bus = 1'b0;
    for (int i = 0; i < NUM_MA; i++)
      if (tri_e[i]) y_bus = y_bus | inst_out(i, fault_mode, abcd);
  end

  always @(negedge clk) begin
    if ($countones(tri_e) > 1) bus_viol++;
    if (tri_prev != '0 && tri_e != '0 && tri_prev != tri_e) bus_viol++;
    tri_prev = tri_e;
  end

  task automatic check(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int err_of(input int i);
    return int'(err_cnt[5*i +: 5]);
  endfunction

  // Waits (bounded) for done; counts negedges from the current one.
  task automatic wait_done(input int inject, output int n);
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      start = (inject != 0 && (n == 50 || n == 51 || n == 150)) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic run_sweep(input int inject, output int n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(inject, n);
  endtask

  task automatic check_counts(input string tag, input int e0, input int e1,
                              input int e2, input int e3, input int dv);
    check({tag, " err0"}, err_of(0), e0);
    check({tag, " err1"}, err_of(1), e1);
    check({tag, " err2"}, err_of(2), e2);
    check({tag, " err3"}, err_of(3), e3);
    check({tag, " div"}, int'(div_cnt), dv);
  endtask

  initial begin
    vec_cnt = 0; bad_cnt = 0; bus_viol = 0; fault_mode = 0; tri_prev = '0;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset tri_e", int'(tri_e), 0);
    check("reset abcd", int'(abcd), 0);
    check("reset err_cnt", int'(err_cnt), 0);
    check("reset div_cnt", int'(div_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal instances
    run_sweep(0, lat);
    check("ideal latency", lat, SWEEP);
    check("ideal busy at done", int'(busy), 1);
    check_counts("ideal", 0, 0, 0, 0, 0);
    @(negedge clk);
    check("ideal busy after", int'(busy), 0);
    check("ideal done pulse", int'(done), 0);
    check("ideal abcd held", int'(abcd), 15);

    // Instance 1 wrong function, start pokes during the sweep and in DONE
    fault_mode = 1;
    run_sweep(1, lat);
    check("fault1 latency", lat, SWEEP);
    check_counts("fault1", 0, 6, 0, 0, 6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done-start idle", int'(busy), 0);
    @(negedge clk);
    check("done-start ignored", int'(busy), 0);
    check_counts("fault1 held", 0, 6, 0, 0, 6);

    // Reset 100 cycles into a sweep
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre-abort busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort tri_e", int'(tri_e), 0);
    check("abort abcd", int'(abcd), 0);
    check("abort div", int'(div_cnt), 0);
    check("abort err", int'(err_cnt), 0);
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort no done", done_seen, 0);
    run_sweep(0, lat);
    check("restart latency", lat, SWEEP);
    check_counts("restart", 0, 6, 0, 0, 6);
    @(negedge clk);

    // Instance 3 stuck-at-0
    fault_mode = 2;
    run_sweep(0, lat);
    check("stuck latency", lat, SWEEP);
    check_counts("stuck", 0, 0, 0, 9, 9);
    @(negedge clk);

    // start held high: second sweep only after IDLE
    fault_mode = 0;
    start = 1'b1;
    @(negedge clk);
    wait_done(0, lat);
    start = 1'b1;
    check("held first latency", lat, SWEEP);
    lat2 = 0;
    @(negedge clk);
    lat2++;
    while (done !== 1'b1 && lat2 < 1000) begin
      @(negedge clk);
      lat2++;
    end
    start = 1'b0;
    check("held done spacing", lat2, SWEEP + 2);
    check_counts("held", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("held idle", int'(busy), 0);

    check("bus contention", bus_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
    $finish;
  end

endmodule
